// File: rtl/register_array_pkg.sv
`timescale 1ns/1ps
// Shared types for the register array and its busy scoreboard.
// Latency: none (types only).
// Backpressure: none (types only).
package register_array_pkg;

    // Clear sequencer state: INIT zeroes the array after reset, RUN is normal operation.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } register_state_type;

endpackage

// File: rtl/register_scoreboard.sv
`timescale 1ns/1ps
// Per-register busy vector: set on issue, cleared on writeback, set wins on collision.
// Latency: updates visible one edge after issue/writeback; rbusy lookup is combinational.
// Backpressure: none; updates are dropped while the array is still clearing.
module register_scoreboard
    import register_array_pkg::*;
#(
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  register_state_type    state,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  wren,
    input  logic [AW-1:0]         waddr,
    input  logic [NRD-1:0]        rden,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD-1:0]        rbusy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Next busy vector: clear first, then set, so a fresh producer overrides a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (state == RUN) begin
            if (wren && (waddr != '0)) begin
                busy_nxt[waddr] = 1'b0;
            end
            if (issue_en && (issue_addr != '0)) begin
                busy_nxt[issue_addr] = 1'b1;
            end
        end
        // x0 never has a producer.
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register; reset clears every pending mark immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Per-port busy lookup, only meaningful once the array is running.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = (state == RUN) & rden[i] & busy[raddr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/register_array.sv
`timescale 1ns/1ps
// Parametrised register file with post-reset clear sequencer and busy scoreboard.
// Latency: reads and rbusy combinational; writes land on the next clk edge; ready NREG cycles after reset.
// Backpressure: none; while ready is low writes and issues are dropped. REGISTER_BYPASS_EN adds write-to-read forwarding.
module register_array
    import register_array_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [NRD-1:0]        rden,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  wren,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    output logic                  ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

    register_state_type state;
    logic [AW-1:0]      cnt;
    logic [XLEN-1:0]    mem [NREG];
    logic [NRD-1:0]     rbusy_sb;

    // Clear sequencer: walk every address once after reset, then stay in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == LAST_ADDR) begin
                state <= RUN;
            end
        end
    end

    assign ready = (state == RUN);

    // Storage: zero fill during INIT, writeback during RUN; x0 is never written by writeback.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (wren && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    register_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wren       (wren),
        .waddr      (waddr),
        .rden       (rden),
        .raddr      (raddr),
        .rbusy      (rbusy_sb)
    );

    // Read muxes: gated to zero for disabled ports, x0, and while clearing.
    always_comb begin
        logic [AW-1:0] a;
        a     = '0;
        rdata = '0;
        rbusy = rbusy_sb;
        for (int i = 0; i < NRD; i++) begin
            a = raddr[i*AW +: AW];
            if ((state == RUN) && rden[i] && (a != '0)) begin
                rdata[i*XLEN +: XLEN] = mem[a];
            end
`ifdef REGISTER_BYPASS_EN
            // Forward the in-flight writeback; its producer retires this edge so the port is not busy.
            if ((state == RUN) && rden[i] && wren && (waddr == a) && (waddr != '0)) begin
                rdata[i*XLEN +: XLEN] = wdata;
                rbusy[i]              = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_array.sv
`timescale 1ns/1ps
// Directed bench for register_array: stimulus pushes expectations, a negedge monitor pops and compares.
// Latency: checks sample outputs mid-cycle, half a period after inputs settle.
// Backpressure: none.
module tb_register_array;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD-1:0]       rden;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 wren;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic                 ready;

    register_array #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .rst        (rst),
        .clk        (clk),
        .rden       (rden),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .wren       (wren),
        .waddr      (waddr),
        .wdata      (wdata),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_RDATA = 2'd0;
    localparam logic [1:0] K_RBUSY = 2'd1;
    localparam logic [1:0] K_READY = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  port;
        logic [31:0] exp;
        logic [15:0] id;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   fails  = 0;
    int   chk_id = 0;

    function automatic string kind_name(input logic [1:0] k);
        case (k)
            K_RDATA: return "rdata";
            K_RBUSY: return "rbusy";
            default: return "ready";
        endcase
    endfunction

    task automatic expect_v(input logic [1:0] kind, input int port, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.port = 8'(port);
        e.exp  = v;
        e.id   = 16'(chk_id);
        chk_id++;
        sbq.push_back(e);
    endtask

    // Monitor: drain every expectation issued for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = '0;
            case (e.kind)
                K_RDATA: act = rdata[e.port*XLEN +: XLEN];
                K_RBUSY: act = {31'b0, rbusy[e.port]};
                default: act = {31'b0, ready};
            endcase
            tests++;
            if (act !== e.exp) begin
                fails++;
                $display("FAIL chk%0d %s[%0d] at %0t: got %h, want %h",
                         e.id, kind_name(e.kind), e.port, $time, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren       = 1'b0;
        waddr      = '0;
        wdata      = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
        rden       = '0;
        raddr      = '0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
        rden[p]          = en;
        raddr[p*AW +: AW] = a;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wren  = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish before 100000ns");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();

        // Held in reset: not ready, nothing visible.
        set_rd(0, 1'b1, AW'(5));
        set_rd(1, 1'b1, AW'(31));
        expect_v(K_READY, 0, 32'd0);
        expect_v(K_RDATA, 0, 32'd0);
        expect_v(K_RDATA, 1, 32'd0);
        expect_v(K_RBUSY, 0, 32'd0);
        step();
        rst = 1'b0;

        // Clear sequence: NREG cycles of not-ready; a write and issue to x4 midway must be dropped.
        for (int c = 0; c < NREG; c++) begin
            idle();
            set_rd(0, 1'b1, AW'((c % 31) + 1));
            set_rd(1, 1'b1, AW'(31 - (c % 31)));
            if (c == 10) begin
                do_write(AW'(4), 32'h0000_00FF);
                do_issue(AW'(4));
            end
            expect_v(K_READY, 0, 32'd0);
            expect_v(K_RDATA, 0, 32'd0);
            expect_v(K_RDATA, 1, 32'd0);
            expect_v(K_RBUSY, 0, 32'd0);
            expect_v(K_RBUSY, 1, 32'd0);
            step();
        end

        // Now running: every register reads zero and is idle (includes x4).
        for (int a = 1; a < NREG; a++) begin
            idle();
            set_rd(0, 1'b1, AW'(a));
            set_rd(1, 1'b1, AW'(NREG - a));
            expect_v(K_READY, 0, 32'd1);
            expect_v(K_RDATA, 0, 32'd0);
            expect_v(K_RDATA, 1, 32'd0);
            expect_v(K_RBUSY, 0, 32'd0);
            expect_v(K_RBUSY, 1, 32'd0);
            step();
        end

        // Write x5 then read on both ports.
        idle();
        do_write(AW'(5), 32'hDEAD_BEEF);
        step();
        idle();
        set_rd(0, 1'b1, AW'(5));
        set_rd(1, 1'b1, AW'(5));
        expect_v(K_RDATA, 0, 32'hDEAD_BEEF);
        expect_v(K_RDATA, 1, 32'hDEAD_BEEF);
        step();

        // Write to x0 is dropped.
        idle();
        do_write(AW'(0), 32'h0000_1234);
        step();
        idle();
        set_rd(0, 1'b1, AW'(0));
        set_rd(1, 1'b1, AW'(0));
        expect_v(K_RDATA, 0, 32'd0);
        expect_v(K_RDATA, 1, 32'd0);
        step();

        // x7 = 0x11, mark busy, then write and read it in the same cycle.
        idle();
        do_write(AW'(7), 32'h0000_0011);
        step();
        idle();
        do_issue(AW'(7));
        step();
        idle();
        do_write(AW'(7), 32'hA5A5_A5A5);
        set_rd(0, 1'b1, AW'(7));
        set_rd(1, 1'b1, AW'(5));
`ifdef REGISTER_BYPASS_EN
        expect_v(K_RDATA, 0, 32'hA5A5_A5A5);
        expect_v(K_RBUSY, 0, 32'd0);
`else
        expect_v(K_RDATA, 0, 32'h0000_0011);
        expect_v(K_RBUSY, 0, 32'd1);
`endif
        expect_v(K_RDATA, 1, 32'hDEAD_BEEF);
        expect_v(K_RBUSY, 1, 32'd0);
        step();
        idle();
        set_rd(0, 1'b1, AW'(7));
        expect_v(K_RDATA, 0, 32'hA5A5_A5A5);
        expect_v(K_RBUSY, 0, 32'd0);
        step();

        // Scoreboard: issue x9, then collide issue+write, then lone write with issue to x10.
        idle();
        do_issue(AW'(9));
        step();
        idle();
        set_rd(0, 1'b1, AW'(9));
        expect_v(K_RBUSY, 0, 32'd1);
        expect_v(K_RDATA, 0, 32'd0);
        step();
        idle();
        do_issue(AW'(9));
        do_write(AW'(9), 32'h0000_0099);
        set_rd(0, 1'b0, AW'(9));
        expect_v(K_RDATA, 0, 32'd0);
        expect_v(K_RBUSY, 0, 32'd0);
        step();
        idle();
        set_rd(0, 1'b1, AW'(9));
        expect_v(K_RBUSY, 0, 32'd1);
        expect_v(K_RDATA, 0, 32'h0000_0099);
        step();
        idle();
        do_write(AW'(9), 32'h0000_009A);
        do_issue(AW'(10));
        step();
        idle();
        set_rd(0, 1'b1, AW'(9));
        set_rd(1, 1'b1, AW'(10));
        expect_v(K_RDATA, 0, 32'h0000_009A);
        expect_v(K_RBUSY, 0, 32'd0);
        expect_v(K_RBUSY, 1, 32'd1);
        step();

        // Issue to x0 never marks it busy.
        idle();
        do_issue(AW'(0));
        step();
        idle();
        set_rd(0, 1'b1, AW'(0));
        expect_v(K_RBUSY, 0, 32'd0);
        expect_v(K_RDATA, 0, 32'd0);
        step();

        // Mid-run reset with x3 = 0x55 and busy.
        idle();
        do_write(AW'(3), 32'h0000_0055);
        step();
        idle();
        do_issue(AW'(3));
        step();
        idle();
        set_rd(0, 1'b1, AW'(3));
        expect_v(K_READY, 0, 32'd1);
        expect_v(K_RDATA, 0, 32'h0000_0055);
        expect_v(K_RBUSY, 0, 32'd1);
        step();
        idle();
        set_rd(0, 1'b1, AW'(3));
        rst = 1'b1;
        expect_v(K_READY, 0, 32'd0);
        expect_v(K_RBUSY, 0, 32'd0);
        expect_v(K_RDATA, 0, 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < NREG; c++) begin
            set_rd(0, 1'b1, AW'(3));
            expect_v(K_READY, 0, 32'd0);
            expect_v(K_RDATA, 0, 32'd0);
            step();
        end
        set_rd(0, 1'b1, AW'(3));
        expect_v(K_READY, 0, 32'd1);
        expect_v(K_RDATA, 0, 32'd0);
        expect_v(K_RBUSY, 0, 32'd0);
        step();

        idle();
        step();
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_array.md
Name: register_array

Overview:
- Parametrised successor of the integer register file.
- Configurable data width, register count and number of read ports.
- Holds a post-reset clear sequencer: all entries are zeroed after reset, so no entry reads X.
- Holds a per-register busy scoreboard: pending writebacks are visible to issue logic.
- Sits between decode (reads, issue) and writeback (write) in the pipeline.

Parameters:
- XLEN, 32: data width of each register.
- NREG, 32: number of registers. Must be a power of two, ≥ 2.
- NRD, 2: number of independent read ports, ≥ 1.
- AW, $clog2(NREG): derived localparam, address width. Not overridable.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock, rising edge
- rden  in  NRD  per-port read enable
- raddr  in  NRD*AW  per-port read address; port i at bits [i*AW +: AW]
- rdata  out  NRD*XLEN  per-port read data; port i at bits [i*XLEN +: XLEN]
- rbusy  out  NRD  per-port flag: addressed register has a pending write
- wren  in  1  writeback enable
- waddr  in  AW  writeback address
- wdata  in  XLEN  writeback data
- issue_en  in  1  marks issue_addr as having a pending write
- issue_addr  in  AW  destination register of the issuing instruction
- ready  out  1  high once the clear sequence has completed

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: FSM state = INIT, clear counter = 0, ready = 0, all busy bits = 0.
- Reset asserted mid-operation: ready drops and busy bits clear immediately, without waiting for a clock edge. The FSM restarts INIT from address 0.
- FSM INIT:
  - Each cycle writes 0 to reg[cnt], then cnt increments.
  - When cnt = NREG-1 is written, the FSM moves to RUN. ready = 1 from the following cycle.
  - Total: exactly NREG cycles from reset release to ready = 1.
- While in INIT:
  - wren and issue_en are ignored.
  - All rdata = 0, all rbusy = 0.
- FSM RUN: stays in RUN until rst. There is no other exit.
- Reads (RUN), combinational, zero latency:
  - rdata[i] = reg[raddr[i]] when rden[i] = 1; otherwise 0.
  - raddr[i] = 0 always returns 0.
- Writes (RUN): reg[waddr] <= wdata on the clk edge when wren = 1 and waddr ≠ 0. A write to address 0 is dropped.
- Read-during-write without bypass: a read in the same cycle returns the old value. The new value is visible from the next cycle.
- Scoreboard (RUN):
  - issue_en with issue_addr ≠ 0 sets busy[issue_addr] at the next edge.
  - wren with waddr ≠ 0 clears busy[waddr] at the next edge.
  - Issue and write to the same address in the same cycle: set wins, because a new producer is outstanding.
  - Issue to address 0 is ignored; busy[0] is constantly 0.
  - Different addresses in the same cycle: both updates apply.
- rbusy[i] = rden[i] & busy[raddr[i]], combinational.
- All read ports are independent. Any ports may address the same register in the same cycle.

Optional Feature:
- Macro REGISTER_BYPASS_EN.
- Defined: write-to-read forwarding on every read port. For port i, when all of the following hold:
  - wren = 1
  - waddr = raddr[i]
  - waddr ≠ 0
  - rden[i] = 1
  - FSM is in RUN
  
  then rdata[i] = wdata and rbusy[i] = 0 in the same cycle.
- Not defined: no forwarding. rdata returns the stored value and rbusy reflects the registered busy bit, which is still set that cycle.

Decomposition:
- Shared package (wires): register_state_type enum {INIT, RUN}.
- Natural sub-module: register_scoreboard.
  - Contains the NREG-bit busy vector with its set/clear priority and async reset.
  - Outputs the NRD rbusy flags.
- register_array keeps the storage array, the clear FSM, the read muxes and the bypass logic.

Test Plan:
- Reset, then read every port at addresses 1..NREG-1 → ready is low for exactly 32 cycles with defaults, all rdata = 0 throughout and after.
- RUN: write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 next cycle → both return 0xDEADBEEF. Write 0x1234 to x0, then read x0 → 0.
- Same-cycle write 0xA5A5A5A5 to x7 and read x7:
  - Without REGISTER_BYPASS_EN → rdata = old value, rbusy follows busy[7].
  - With REGISTER_BYPASS_EN → rdata = 0xA5A5A5A5, rbusy = 0.
- Scoreboard: issue x9 → rbusy = 1 next cycle. Then issue and wren on x9 in the same cycle → busy stays 1. A lone wren on x9 → busy = 0.
- Assert rst for one cycle mid-RUN with x3 busy and x3 = 0x55:
  - ready = 0 and rbusy = 0 immediately.
  - After NREG cycles: ready = 1 and x3 reads 0.
- During INIT: wren to x4 with 0xFF and issue to x4 → both ignored; after ready = 1, x4 reads 0 and is not busy.
